nwr_resp: RTL and testbench

NWR_RESP -- requirements
Module: nwr_resp

---
 rtl/nwr_resp.sv | 201 ++++++++++++++++++++
 tb/tb_nwr_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nwr_resp.sv
// rtl/nwr_resp.sv - NWRITE/NWRITE_R target: payload write port plus response beat
//
// Accepts HELLO-format NWRITE / NWRITE_R requests on the treq stream, forwards the
// payload beats to the user write port with incrementing addresses, drops anything
// else, and returns a single-beat response for NWRITE_R.
//
// Ports:
//   log_clk, log_rst_n             clock, asynchronous active-low reset
//   src_id, des_id                 local ID, expected requester ID (quasi-static)
//   treq_*                         request stream (tdata/tkeep/tuser/tlast, valid/ready)
//   tresp_*                        response stream, registered single beat
//   user_wr_*                      payload write port (combinational pass-through)
//   pkt_cnt_o, err_cnt_o           saturating accepted-request and error counters
module nwr_resp #(
  parameter int MAX_BEATS = 32
) (
  input  logic        log_clk,
  input  logic        log_rst_n,
  input  logic [15:0] src_id,
  input  logic [15:0] des_id,
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  input  logic        treq_tlast_in,
  input  logic        tresp_tready_in,
  output logic        tresp_tvalid_o,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  output logic        user_wr_valid_o,
  input  logic        user_wr_ready_in,
  output logic [33:0] user_wr_addr_o,
  output logic [63:0] user_wr_data_o,
  output logic [7:0]  user_wr_keep_o,
  output logic        user_wr_last_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, DATA, DROP, RESP} state_t;
  state_t state;

  logic [7:0]  tid_q;
  logic [3:0]  ttype_q;
  logic [1:0]  prio_q;
  logic        crf_q;
  logic [7:0]  size_q;
  logic [33:0] addr_q;
  logic [15:0] req_id_q;
  logic [15:0] beat_q;

  // Header fields straight off the incoming beat (only meaningful in IDLE).
  logic [3:0] in_ftype, in_ttype;
  logic       is_nwr, is_nwr_r;
  assign in_ftype = treq_tdata_in[55:52];
  assign in_ttype = treq_tdata_in[51:48];
  assign is_nwr   = (in_ftype == 4'h5) && ((in_ttype == 4'h4) || (in_ttype == 4'h5));
  assign is_nwr_r = (in_ftype == 4'h5) && (in_ttype == 4'h5);

  // Length check done on the closing beat: beats seen so far including this one.
  logic        beat_over;
  logic [16:0] beats_now, beats_exp;
  logic        len_err;
  assign beat_over = beat_q >= 16'(MAX_BEATS);
  assign beats_now = {1'b0, beat_q} + 17'd1;
  assign beats_exp = {12'd0, size_q[7:3]} + 17'd1;
  assign len_err   = (beats_now != beats_exp) || (beats_now > 17'(MAX_BEATS));

  logic accept;
  assign accept = treq_tvalid_in && treq_tready_o;

  logic unused_ok;
  assign unused_ok = ^{des_id, treq_tuser_in[15:0]};

  always_comb begin
    treq_tready_o   = 1'b0;
    user_wr_valid_o = 1'b0;
    user_wr_addr_o  = '0;
    user_wr_data_o  = '0;
    user_wr_keep_o  = '0;
    user_wr_last_o  = 1'b0;
    case (state)
      IDLE: treq_tready_o = log_rst_n;  // held low while reset is asserted
      DATA: begin
        // Beats past MAX_BEATS are swallowed without reaching the user port.
        treq_tready_o   = beat_over ? 1'b1 : user_wr_ready_in;
        user_wr_valid_o = treq_tvalid_in && !beat_over;
        user_wr_addr_o  = addr_q + 34'({beat_q, 3'b000});
        user_wr_data_o  = treq_tdata_in;
        user_wr_keep_o  = treq_tkeep_in;
        user_wr_last_o  = treq_tlast_in;
      end
      DROP:    treq_tready_o = 1'b1;
      default: treq_tready_o = 1'b0;
    endcase
  end

  // Per-cycle events derived from the current state and handshake.
  logic to_resp, resp_err, err_inc, pkt_inc;
  always_comb begin
    to_resp  = 1'b0;
    resp_err = 1'b0;
    err_inc  = 1'b0;
    pkt_inc  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        err_inc = treq_tlast_in || !is_nwr;
        if (treq_tlast_in && is_nwr_r) begin
          to_resp  = 1'b1;
          resp_err = 1'b1;
        end
      end
      DATA: if (accept && treq_tlast_in) begin
        err_inc  = len_err;
        pkt_inc  = !len_err;
        to_resp  = (ttype_q == 4'h5);
        resp_err = len_err;
      end
      DROP: if (accept && treq_tlast_in) begin
        to_resp  = (ttype_q == 4'h5);
        resp_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Response built from the live header when answering straight from IDLE.
  logic [7:0]  r_tid;
  logic [1:0]  r_prio, r_prio_up;
  logic        r_crf;
  logic [15:0] r_req;
  assign r_tid     = (state == IDLE) ? treq_tdata_in[63:56] : tid_q;
  assign r_prio    = (state == IDLE) ? treq_tdata_in[46:45] : prio_q;
  assign r_crf     = (state == IDLE) ? treq_tdata_in[44]    : crf_q;
  assign r_req     = (state == IDLE) ? treq_tuser_in[31:16] : req_id_q;
  assign r_prio_up = (r_prio == 2'd3) ? 2'd3 : r_prio + 2'd1;

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state          <= IDLE;
      tid_q          <= '0;
      ttype_q        <= '0;
      prio_q         <= '0;
      crf_q          <= 1'b0;
      size_q         <= '0;
      addr_q         <= '0;
      req_id_q       <= '0;
      beat_q         <= '0;
      tresp_tvalid_o <= 1'b0;
      tresp_tlast_o  <= 1'b0;
      tresp_tdata_o  <= '0;
      tresp_tkeep_o  <= '0;
      tresp_tuser_o  <= '0;
      pkt_cnt_o      <= '0;
      err_cnt_o      <= '0;
    end else begin
      if (err_inc && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      if (pkt_inc && pkt_cnt_o != 16'hFFFF) pkt_cnt_o <= pkt_cnt_o + 16'd1;
      if (to_resp) begin
        tresp_tvalid_o <= 1'b1;
        tresp_tlast_o  <= 1'b1;
        tresp_tkeep_o  <= 8'hFF;
        tresp_tdata_o  <= {r_tid, 4'hD, 4'h0, 1'b0, r_prio_up, r_crf, 8'h00,
                           (resp_err ? 4'h7 : 4'h0), 32'h0};
        tresp_tuser_o  <= {src_id, r_req};
      end
      case (state)
        IDLE: if (accept) begin
          tid_q    <= treq_tdata_in[63:56];
          ttype_q  <= in_ttype;
          prio_q   <= treq_tdata_in[46:45];
          crf_q    <= treq_tdata_in[44];
          size_q   <= treq_tdata_in[43:36];
          addr_q   <= treq_tdata_in[33:0];
          req_id_q <= treq_tuser_in[31:16];
          beat_q   <= '0;
          if (to_resp)             state <= RESP;
          else if (!treq_tlast_in) state <= is_nwr ? DATA : DROP;
        end
        DATA: if (accept) begin
          if (beat_q != 16'hFFFF) beat_q <= beat_q + 16'd1;
          if (treq_tlast_in) state <= to_resp ? RESP : IDLE;
        end
        DROP: if (accept && treq_tlast_in) state <= to_resp ? RESP : IDLE;
        RESP: if (tresp_tready_in) begin
          state          <= IDLE;
          tresp_tvalid_o <= 1'b0;
          tresp_tlast_o  <= 1'b0;
          tresp_tkeep_o  <= '0;
          tresp_tdata_o  <= '0;
          tresp_tuser_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nwr_resp.sv
// tb/tb_nwr_resp.sv - self-checking bench for nwr_resp
module tb_nwr_resp;

  logic        log_clk;
  logic        log_rst_n;
  logic [15:0] src_id, des_id;
  logic        treq_tvalid_in, treq_tready_o, treq_tlast_in;
  logic [63:0] treq_tdata_in;
  logic [7:0]  treq_tkeep_in;
  logic [31:0] treq_tuser_in;
  logic        tresp_tready_in, tresp_tvalid_o, tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;
  logic        user_wr_valid_o, user_wr_ready_in, user_wr_last_o;
  logic [33:0] user_wr_addr_o;
  logic [63:0] user_wr_data_o;
  logic [7:0]  user_wr_keep_o;
  logic [15:0] pkt_cnt_o, err_cnt_o;

  int checks = 0;
  int failures = 0;

  nwr_resp dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n), .src_id(src_id), .des_id(des_id),
    .treq_tvalid_in(treq_tvalid_in), .treq_tready_o(treq_tready_o),
    .treq_tdata_in(treq_tdata_in), .treq_tkeep_in(treq_tkeep_in),
    .treq_tuser_in(treq_tuser_in), .treq_tlast_in(treq_tlast_in),
    .tresp_tready_in(tresp_tready_in), .tresp_tvalid_o(tresp_tvalid_o),
    .tresp_tlast_o(tresp_tlast_o), .tresp_tdata_o(tresp_tdata_o),
    .tresp_tkeep_o(tresp_tkeep_o), .tresp_tuser_o(tresp_tuser_o),
    .user_wr_valid_o(user_wr_valid_o), .user_wr_ready_in(user_wr_ready_in),
    .user_wr_addr_o(user_wr_addr_o), .user_wr_data_o(user_wr_data_o),
    .user_wr_keep_o(user_wr_keep_o), .user_wr_last_o(user_wr_last_o),
    .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  initial log_clk = 1'b0;
  always #5 log_clk = ~log_clk;

  typedef struct {
    logic        v, l;
    logic [63:0] d;
    logic [31:0] u;
    logic        wr, rr;
    logic        erdy, ewv;
    logic [33:0] ea;
    logic [63:0] ed;
    logic        ewl, erv;
    logic [63:0] erd;
    logic [31:0] eru;
    logic [15:0] ep, ee;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft, tt,
                                      input logic [1:0] pr, input logic crf,
                                      input logic [7:0] sz, input logic [33:0] a);
    hdr = {tid, ft, tt, 1'b0, pr, crf, sz, 2'b00, a};
  endfunction

  task automatic add(input logic v, l, input logic [63:0] d, input logic [31:0] u,
                     input logic wr, rr, input logic erdy, ewv, input logic [33:0] ea,
                     input logic [63:0] ed, input logic ewl, erv, input logic [63:0] erd,
                     input logic [31:0] eru, input logic [15:0] ep, ee);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.u = u; t.wr = wr; t.rr = rr;
    t.erdy = erdy; t.ewv = ewv; t.ea = ea; t.ed = ed; t.ewl = ewl; t.erv = erv;
    t.erd = erd; t.eru = eru; t.ep = ep; t.ee = ee;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, l, input logic [63:0] d, input logic [31:0] u,
                       input logic wr, rr);
    treq_tvalid_in   = v;
    treq_tlast_in    = l;
    treq_tdata_in    = d;
    treq_tkeep_in    = d[7:0];
    treq_tuser_in    = u;
    user_wr_ready_in = wr;
    tresp_tready_in  = rr;
  endtask

  // Response last/keep follow valid; user keep follows the expected data's low byte
  // because the stimulus always drives tkeep = tdata[7:0].
  task automatic obs_check(input string name, input logic erdy, ewv, input logic [33:0] ea,
                           input logic [63:0] ed, input logic ewl, erv,
                           input logic [63:0] erd, input logic [31:0] eru,
                           input logic [15:0] ep, ee);
    logic [246:0] act, exp;
    act = {treq_tready_o, user_wr_valid_o, user_wr_addr_o, user_wr_data_o, user_wr_keep_o,
           user_wr_last_o, tresp_tvalid_o, tresp_tlast_o, tresp_tkeep_o, tresp_tdata_o,
           tresp_tuser_o, pkt_cnt_o, err_cnt_o};
    exp = {erdy, ewv, ea, ed, ed[7:0], ewl, erv, erv, (erv ? 8'hFF : 8'h00), erd, eru, ep, ee};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge log_clk);
    @(negedge log_clk);
  endtask

  initial begin
    logic [63:0] h;
    logic [33:0] a;
    log_rst_n = 1'b0;
    src_id = 16'h00F0;
    des_id = 16'h0001;
    drive(0, 0, 64'h0, 32'h0, 0, 0);

    // NWRITE 0x100, 4 beats
    h = hdr(8'h01, 4'h5, 4'h4, 2'd0, 1'b0, 8'h1F, 34'h100);
    add(1, 0, h, 32'h0009_0000, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    add(1, 0, 64'h1111, 32'h0, 1, 0, 1, 1, 34'h100, 64'h1111, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    add(1, 0, 64'h2222, 32'h0, 1, 0, 1, 1, 34'h108, 64'h2222, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    add(1, 0, 64'h3333, 32'h0, 1, 0, 1, 1, 34'h110, 64'h3333, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    add(1, 1, 64'h4444, 32'h0, 1, 0, 1, 1, 34'h118, 64'h4444, 1, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd1, 16'd0);
    // NWRITE_R TID 5A, PRIO 1, 1 beat -> DONE
    h = hdr(8'h5A, 4'h5, 4'h5, 2'd1, 1'b0, 8'h07, 34'h200);
    add(1, 0, h, 32'h0001_00F0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd1, 16'd0);
    add(1, 1, 64'h5555, 32'h0, 1, 0, 1, 1, 34'h200, 64'h5555, 1, 0, 64'h0, 32'h0, 16'd1, 16'd0);
    add(0, 0, 64'h0, 32'h0, 1, 1, 0, 0, 34'h0, 64'h0, 0, 1, 64'h5AD0_4000_0000_0000, 32'h00F0_0001, 16'd2, 16'd0);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd0);
    // NWRITE_R SIZE 0F with 3 beats -> ERROR, PRIO 3 saturates, CRF set
    h = hdr(8'h33, 4'h5, 4'h5, 2'd3, 1'b1, 8'h0F, 34'h300);
    add(1, 0, h, 32'h0002_0000, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd0);
    add(1, 0, 64'h6666, 32'h0, 1, 0, 1, 1, 34'h300, 64'h6666, 0, 0, 64'h0, 32'h0, 16'd2, 16'd0);
    add(1, 0, 64'h7777, 32'h0, 1, 0, 1, 1, 34'h308, 64'h7777, 0, 0, 64'h0, 32'h0, 16'd2, 16'd0);
    add(1, 1, 64'h8888, 32'h0, 1, 0, 1, 1, 34'h310, 64'h8888, 1, 0, 64'h0, 32'h0, 16'd2, 16'd0);
    add(0, 0, 64'h0, 32'h0, 1, 1, 0, 0, 34'h0, 64'h0, 0, 1, 64'h33D0_7007_0000_0000, 32'h00F0_0002, 16'd2, 16'd1);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd1);
    // Doorbell FTYPE 10 + 1 extra beat -> dropped
    h = hdr(8'h44, 4'hA, 4'h0, 2'd0, 1'b0, 8'h07, 34'h500);
    add(1, 0, h, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd1);
    add(1, 1, 64'h9999, 32'h0, 0, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    // Back-pressure: user ready toggles, response held 5 cycles
    h = hdr(8'h11, 4'h5, 4'h5, 2'd0, 1'b0, 8'h0F, 34'h400);
    add(1, 0, h, 32'h0004_0000, 0, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    add(1, 0, 64'hAAAA, 32'h0, 0, 0, 0, 1, 34'h400, 64'hAAAA, 0, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    add(1, 0, 64'hAAAA, 32'h0, 1, 0, 1, 1, 34'h400, 64'hAAAA, 0, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    add(1, 1, 64'hBBBB, 32'h0, 0, 0, 0, 1, 34'h408, 64'hBBBB, 1, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    add(1, 1, 64'hBBBB, 32'h0, 1, 0, 1, 1, 34'h408, 64'hBBBB, 1, 0, 64'h0, 32'h0, 16'd2, 16'd2);
    for (int k = 0; k < 5; k++)
      add(0, 0, 64'h0, 32'h0, 1, 0, 0, 0, 34'h0, 64'h0, 0, 1, 64'h11D0_2000_0000_0000, 32'h00F0_0004, 16'd3, 16'd2);
    add(0, 0, 64'h0, 32'h0, 1, 1, 0, 0, 34'h0, 64'h0, 0, 1, 64'h11D0_2000_0000_0000, 32'h00F0_0004, 16'd3, 16'd2);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd3, 16'd2);
    // Header-only NWRITE_R -> ERROR response; header-only NWRITE -> no response
    h = hdr(8'h77, 4'h5, 4'h5, 2'd2, 1'b0, 8'h07, 34'h0);
    add(1, 1, h, 32'h0003_0000, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd3, 16'd2);
    add(0, 0, 64'h0, 32'h0, 1, 1, 0, 0, 34'h0, 64'h0, 0, 1, 64'h77D0_6007_0000_0000, 32'h00F0_0003, 16'd3, 16'd3);
    h = hdr(8'h78, 4'h5, 4'h4, 2'd0, 1'b0, 8'h07, 34'h0);
    add(1, 1, h, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd3, 16'd3);
    add(0, 0, 64'h0, 32'h0, 1, 0, 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd3, 16'd4);

    // Reset state
    @(negedge log_clk);
    @(negedge log_clk);
    #1 obs_check("reset_state", 0, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    @(negedge log_clk);
    log_rst_n = 1'b1;
    #1 obs_check("first_cycle_ready", 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].u, vecs[i].wr, vecs[i].rr);
      #1 obs_check($sformatf("vec%0d", i), vecs[i].erdy, vecs[i].ewv, vecs[i].ea, vecs[i].ed,
                   vecs[i].ewl, vecs[i].erv, vecs[i].erd, vecs[i].eru, vecs[i].ep, vecs[i].ee);
      step();
    end

    // 33 beats against SIZE FF (32 expected), address wraps through 2^34
    drive(1, 0, hdr(8'h20, 4'h5, 4'h4, 2'd0, 1'b0, 8'hFF, 34'h3_FFFF_FFF0), 32'h0, 1, 0);
    step();
    a = 34'h3_FFFF_FFF0;
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 64'hC000 + 64'(i), 32'h0, 1, 0);
      #1 obs_check($sformatf("ovf_beat%0d", i), 1, 1, a, 64'hC000 + 64'(i), 0, 0, 64'h0, 32'h0, 16'd3, 16'd4);
      a = a + 34'd8;
      step();
    end
    drive(1, 1, 64'hC0FF, 32'h0, 0, 0);
    #1 obs_check("ovf_extra_beat", 1, 0, 34'h0 + a, 64'hC0FF, 1, 0, 64'h0, 32'h0, 16'd3, 16'd4);
    step();
    drive(0, 0, 64'h0, 32'h0, 1, 0);
    #1 obs_check("ovf_err", 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd3, 16'd5);

    // Exactly MAX_BEATS beats is a good packet
    drive(1, 0, hdr(8'h21, 4'h5, 4'h4, 2'd0, 1'b0, 8'hFF, 34'h1000), 32'h0, 1, 0);
    step();
    for (int i = 0; i < 32; i++) begin
      drive(1, (i == 31), 64'hE000 + 64'(i), 32'h0, 1, 0);
      step();
    end
    drive(0, 0, 64'h0, 32'h0, 1, 0);
    #1 obs_check("max_beats_ok", 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd4, 16'd5);

    // Reset in the 2nd of 4 data beats
    drive(1, 0, hdr(8'h66, 4'h5, 4'h5, 2'd0, 1'b0, 8'h1F, 34'h600), 32'h0005_0000, 1, 0);
    step();
    drive(1, 0, 64'hD000, 32'h0, 1, 0);
    step();
    drive(1, 0, 64'hD001, 32'h0, 1, 0);
    #1 obs_check("mid_pkt_beat2", 1, 1, 34'h608, 64'hD001, 0, 0, 64'h0, 32'h0, 16'd4, 16'd5);
    #1 log_rst_n = 1'b0;
    #1 obs_check("mid_pkt_reset", 0, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    drive(0, 0, 64'h0, 32'h0, 1, 0);
    step();
    log_rst_n = 1'b1;
    #1 obs_check("after_release", 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    step();
    drive(1, 0, hdr(8'h66, 4'h5, 4'h5, 2'd0, 1'b0, 8'h07, 34'h700), 32'h0005_0000, 1, 0);
    step();
    drive(1, 1, 64'hCCCC, 32'h0, 1, 0);
    #1 obs_check("clean_beat", 1, 1, 34'h700, 64'hCCCC, 1, 0, 64'h0, 32'h0, 16'd0, 16'd0);
    step();
    drive(0, 0, 64'h0, 32'h0, 1, 1);
    #1 obs_check("clean_resp", 0, 0, 34'h0, 64'h0, 0, 1, 64'h66D0_2000_0000_0000, 32'h00F0_0005, 16'd1, 16'd0);
    step();
    drive(0, 0, 64'h0, 32'h0, 1, 0);
    #1 obs_check("clean_idle", 1, 0, 34'h0, 64'h0, 0, 0, 64'h0, 32'h0, 16'd1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
